// File: rtl/counter_bank_sched.sv
// Round-robin scheduler over four WIDTH-bit counters sharing one increment path.
// A winner gets a non-preemptive burst of BURST increments, followed by a
// one-cycle DONE state before the next arbitration.
module counter_bank_sched #(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       clr,
  output logic [3:0]       grant,
  output logic             busy,
  output logic             done,
  output logic [3:0]       wrap,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       remaining_reg, remaining_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [3:0]       grant_reg, grant_next;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;
  logic             inc_en;
  logic [WIDTH-1:0] q_all [4];
  logic [3:0]       wrap_all;

  // Rotating-priority scan: the channel just after the last winner is checked first
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    found  = 1'b0;
    for (int o = 1; o <= 4; o++) begin
      cand = ptr_reg + o[1:0];
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Scheduler state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= 8'd0;
      ptr_reg       <= 2'd3;
      grant_reg     <= 4'b0000;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      ptr_reg       <= ptr_next;
      grant_reg     <= grant_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, count down the burst in RUN, release after DONE
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    ptr_next       = ptr_reg;
    grant_next     = grant_reg;
    case (state_reg)
      IDLE: begin
        grant_next = 4'b0000;
        if (found) begin
          grant_next     = 4'b0001 << winner;
          ptr_next       = winner;
          remaining_next = 8'(BURST);
          state_next     = RUN;
        end
      end
      RUN: begin
        remaining_next = remaining_reg - 8'd1;
        if (remaining_reg == 8'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  // The shared increment path is live only while a burst is running
  assign inc_en = (state_reg == RUN);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic [WIDTH-1:0] cnt_reg;
      logic             wrap_reg;

      // Per-channel counter: a clear beats a same-cycle increment, which is then lost
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg  <= '0;
          wrap_reg <= 1'b0;
        end else if (clr[gi]) begin
          cnt_reg  <= '0;
          wrap_reg <= 1'b0;
        end else if (inc_en && grant_reg[gi]) begin
          cnt_reg <= cnt_reg + WIDTH'(1);
          if (&cnt_reg) begin
            wrap_reg <= 1'b1;
          end
        end
      end

      assign q_all[gi]    = cnt_reg;
      assign wrap_all[gi] = wrap_reg;
    end
  endgenerate

  assign grant = grant_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);
  assign wrap  = wrap_all;
  assign q0    = q_all[0];
  assign q1    = q_all[1];
  assign q2    = q_all[2];
  assign q3    = q_all[3];

endmodule

// File: tb/tb_counter_bank_sched.sv
// Bench for counter_bank_sched: fixed vector table, hand-written corner
// sequences and a randomized run against a behavioural burst model.
module tb_counter_bank_sched;
  localparam int WIDTH = 4;
  localparam int BURST = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = 4'b0000;
  logic [3:0]       clr = 4'b0000;
  logic [3:0]       grant;
  logic             busy;
  logic             done;
  logic [3:0]       wrap;
  logic [WIDTH-1:0] q0, q1, q2, q3;

  counter_bank_sched #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .clr(clr),
    .grant(grant), .busy(busy), .done(done), .wrap(wrap),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner = channel holding the path (-1 none),
  // left = increments still owed to it (0 with an owner means the done cycle)
  int         m_q [4];
  logic [3:0] m_wrap;
  int         m_owner;
  int         m_left;
  int         m_ptr;

  typedef struct {
    logic [3:0] req;
    logic [3:0] clr;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    int         q0;
    int         q1;
    logic [3:0] wrap;
  } vec_t;

  vec_t       tbl [13];
  int         starts [$];
  int         gvals [$];
  int         dq2 [$];
  int         dwrap [$];
  logic [3:0] prev_grant;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dq(input int i);
    case (i)
      0: return int'(q0);
      1: return int'(q1);
      2: return int'(q2);
      default: return int'(q3);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_q[i] = 0;
    m_wrap  = 4'b0000;
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 3;
  endtask

  task automatic model_step();
    int c;
    bit got;
    got = 0;
    if (m_owner < 0) begin
      for (int o = 1; o <= 4; o++) begin
        c = (m_ptr + o) % 4;
        if (!got && req[c]) begin
          got     = 1;
          m_owner = c;
          m_ptr   = c;
          m_left  = BURST;
        end
      end
    end else if (m_left > 0) begin
      if (m_q[m_owner] == MAXV) m_wrap[m_owner] = 1'b1;
      m_q[m_owner] = (m_q[m_owner] + 1) % (MAXV + 1);
      m_left--;
    end else begin
      m_owner = -1;
    end
    for (int i = 0; i < 4; i++) begin
      if (clr[i]) begin
        m_q[i]    = 0;
        m_wrap[i] = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    for (int i = 0; i < 4; i++) check($sformatf("%s_q%0d", tag, i), dq(i), m_q[i]);
    check({tag, "_grant"}, int'(grant), eg);
    check({tag, "_busy"}, int'(busy), (m_owner >= 0) ? 1 : 0);
    check({tag, "_done"}, int'(done), (m_owner >= 0 && m_left == 0) ? 1 : 0);
    check({tag, "_wrap"}, int'(wrap), int'(m_wrap));
  endtask

  // One clock edge; the model advances on the same inputs the DUT saw
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'($urandom);
    clr = 4'($urandom);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    req = 4'b0000;
    clr = 4'b0000;
  endtask

  initial begin
    // Channel 0 burst, then channel 1 burst with a clear colliding with its 2nd increment
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 0, 0, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1, 0, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 2, 0, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 3, 0, 4'b0000};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 4, 0, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4, 0, 4'b0000};
    tbl[6]  = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 4, 0, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 4, 1, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0, 4, 0, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 4, 1, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1, 4, 2, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4, 2, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 0, 2, 4'b0000};

    // Reset state with arbitrary req/clr
    do_reset();
    for (int i = 0; i < 4; i++) check($sformatf("reset_q%0d", i), dq(i), 0);
    check("reset_grant", int'(grant), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wrap", int'(wrap), 0);

    // Vector table
    for (int v = 0; v < 13; v++) begin
      req = tbl[v].req;
      clr = tbl[v].clr;
      step();
      $display("vec %0d req=%b clr=%b grant=%b busy=%b done=%b q0=%0d q1=%0d wrap=%b",
               v, req, clr, grant, busy, done, q0, q1, wrap);
      check($sformatf("vec%0d_grant", v), int'(grant), int'(tbl[v].grant));
      check($sformatf("vec%0d_busy", v), int'(busy), int'(tbl[v].busy));
      check($sformatf("vec%0d_done", v), int'(done), int'(tbl[v].done));
      check($sformatf("vec%0d_q0", v), int'(q0), tbl[v].q0);
      check($sformatf("vec%0d_q1", v), int'(q1), tbl[v].q1);
      check($sformatf("vec%0d_q23", v), int'(q2) + int'(q3), 0);
      check($sformatf("vec%0d_wrap", v), int'(wrap), int'(tbl[v].wrap));
    end
    req = 4'b0000;
    clr = 4'b0000;

    // All requesters held: rotation order and BURST+2 spacing
    do_reset();
    req = 4'b1111;
    prev_grant = 4'b0000;
    for (int c = 0; c < 60 && gvals.size() < 5; c++) begin
      step();
      check_model("rr");
      if (prev_grant == 4'b0000 && grant != 4'b0000) begin
        gvals.push_back(int'(grant));
        starts.push_back(c);
        $display("rr grant=%b at cycle %0d", grant, c);
        if (gvals.size() == 5)
          for (int i = 0; i < 4; i++) check($sformatf("rr_round_q%0d", i), dq(i), 4);
      end
      prev_grant = grant;
    end
    check("rr_grant_count", gvals.size(), 5);
    for (int k = 0; k < gvals.size(); k++) begin
      check($sformatf("rr_order%0d", k), gvals[k], 1 << (k % 4));
      if (k > 0) check($sformatf("rr_gap%0d", k), starts[k] - starts[k-1], BURST + 2);
    end
    repeat (BURST) step();
    check("rr_q0_second", int'(q0), 8);
    check("rr_done_second", int'(done), 1);
    req = 4'b0000;

    // Four bursts on channel 2: wrap on the 16th increment, then clear
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 60 && dq2.size() < 4; c++) begin
      step();
      check_model("wrap_run");
      if (done) begin
        dq2.push_back(int'(q2));
        dwrap.push_back(int'(wrap));
        $display("wrap burst done q2=%0d wrap=%b", q2, wrap);
      end
    end
    check("wrap_burst_count", dq2.size(), 4);
    if (dq2.size() == 4) begin
      check("wrap_q2_b1", dq2[0], 4);
      check("wrap_q2_b2", dq2[1], 8);
      check("wrap_q2_b3", dq2[2], 12);
      check("wrap_q2_b4", dq2[3], 0);
      check("wrap_flag_b3", dwrap[2], 0);
      check("wrap_flag_b4", dwrap[3], 4);
    end
    req = 4'b0000;
    clr = 4'b0100;
    step();
    clr = 4'b0000;
    check("wrap_clr_flag", int'(wrap), 0);
    check("wrap_clr_q2", int'(q2), 0);

    // Asynchronous reset in the middle of a burst, then pointer restart
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    check("abort_q0_before", int'(q0), 2);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("abort_q0", int'(q0), 0);
    check("abort_grant", int'(grant), 0);
    check("abort_busy", int'(busy), 0);
    $display("abort rst mid-burst q0=%0d grant=%b busy=%b", q0, grant, busy);
    #1 rst = 1'b0;
    req = 4'b1001;
    step();
    check("abort_restart_grant", int'(grant), 1);
    check_model("abort_restart");
    req = 4'b0000;
    repeat (BURST + 2) begin
      step();
      check_model("abort_drain");
    end

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      clr = ($urandom_range(0, 9) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rand_rst");
        rst = 1'b0;
      end
      step();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
